gshare_pht_predictor: RTL and testbench
=======================================

# gshare_pht_predictor

Global-history branch direction predictor feeding the fetch stage. Holds a global history register (GHR) and a pattern history table (PHT) of 2-bit saturating counters (SNT/WNT/WTK/STK), indexed by PC XOR GHR. It is the table-and-history stage directly around the per-entry 2-bit counter FSM: it selects which counter predicts, and routes execute-stage resolutions back into that counter.

## Interface
- Parameters:
- `PC_W`, 32, fetch PC width
- `IDX_W`, 8, PHT index width; PHT depth = 2**IDX_W
- `GHR_W`, 8, history length; must satisfy 1 <= GHR_W <= IDX_W
- Ports (one clock; reset asynchronous, active-high):
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous active-high reset
- `i_fetch_valid`  in  1  lookup request this cycle
- `i_fetch_pc`  in  PC_W  PC of the fetched instruction
- `o_pred_valid`  out  1  registered; high one cycle after an accepted lookup
- `o_pred_taken`  out  1  predicted direction
- `o_pred_idx`  out  IDX_W  PHT index used; carried down the pipe
- `o_pred_ghr`  out  GHR_W  GHR snapshot used for the index, before the speculative shift
- `i_upd_valid`  in  1  resolved branch from execute
- `i_upd_idx`  in  IDX_W  index returned from `o_pred_idx`
- `i_upd_ghr`  in  GHR_W  snapshot returned from `o_pred_ghr`
- `i_upd_taken`  in  1  actual direction
- `i_upd_mispred`  in  1  direction mispredicted; qualifies GHR recovery
- `o_ghr`  out  GHR_W  current speculative GHR

## Operation
- Index: `idx = i_fetch_pc[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}`.
- Prediction: `o_pred_taken = pht[idx][1]`, i.e. taken for WTK/STK.
- Speculative history: on `i_fetch_valid`, `ghr <= {ghr[GHR_W-2:0], pred_taken}`. For GHR_W=1, `ghr <= pred_taken`.
- Counter update on `i_upd_valid`:
  - taken: SNT->WNT->WTK->STK, saturating at STK.
  - not taken: STK->WTK->WNT->SNT, saturating at SNT.
  - Only `pht[i_upd_idx]` changes.
- Recovery: if `i_upd_valid && i_upd_mispred`, `ghr <= {i_upd_ghr[GHR_W-2:0], i_upd_taken}`.
  - Overrides the same-cycle fetch shift.
  - The same-cycle lookup still produces a prediction, using the pre-recovery GHR.
- `i_upd_mispred` without `i_upd_valid` is ignored.
- Reset values:
  - every PHT entry = SNT; `ghr` = 0
  - `o_pred_valid`, `o_pred_taken`, `o_pred_idx`, `o_pred_ghr` = 0
- Reset mid-operation clears everything immediately, asynchronously. The first lookup after release predicts not-taken.

## Timing
- Lookup latency 1: request at edge N gives outputs valid after edge N+1. Outputs hold until the next accepted lookup; `o_pred_valid` deasserts when no lookup occurs.
- Back-to-back lookups are supported every cycle. The second lookup uses the GHR already shifted by the first.
- Update visible to lookups starting the cycle after `i_upd_valid`.
- Same-cycle lookup and update to the same index: the lookup reads the pre-update counter, unless bypass is enabled (see Configuration).
- `o_ghr` reflects the register value; it changes the cycle after a fetch or a recovery.

## Configuration
- `GSHARE_PHT_BYPASS_EN`:
  - Defined: a same-cycle update to the same index forwards the counter's next state into the lookup. The prediction and the speculative GHR shift use that forwarded value.
  - Undefined: read-before-write behaviour as above.
- PHT write timing is identical in both builds.

## Structure
- Shared package `bp_pkg`:
  - counter state typedef/constants: SNT=2'b00, WNT=2'b01, WTK=2'b10, STK=2'b11
  - the reset state constant (SNT)
- Sub-module `pht_sat_ctr`: purely combinational next-state function (state, taken -> next). Instantiated once on the update path, and reused for the bypass path when the macro is enabled.
- PHT is a flat register array, not an inferred RAM. This allows the asynchronous reset of all entries.

## Test plan
- Reset then lookup PC=0x0000_0010, GHR=0 -> `o_pred_idx`=0x04, `o_pred_taken`=0, `o_pred_ghr`=0x00; `o_ghr`=0x00 after the edge.
- Update idx 0x04 taken three times, then lookup PC=0x10 with GHR forced to 0 via a mispred recovery (`i_upd_ghr`=0x00, `i_upd_taken`=0) -> counter=STK, predict taken. Four more taken updates -> still STK.
- Two lookups with predictions 1 then 0 from GHR=0x00 -> `o_ghr`=0x01 then 0x02.
- Mispredict with `i_upd_ghr`=0x5A, `i_upd_taken`=1 in the same cycle as a fetch -> `o_ghr`=0xB5. The fetch's prediction is still output next cycle with `o_pred_ghr` = pre-recovery GHR.
- Same-cycle lookup/update at idx 0x04 with counter WNT, taken:
  - without `GSHARE_PHT_BYPASS_EN` -> predict 0
  - with it -> predict 1
  - either build: entry = WTK afterwards
- Assert `rst` mid-stream after training entries -> all outputs 0 while `rst` is high; next lookup at any trained index predicts 0.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor blocks.
//   ctr_t      : 2-bit saturating direction counter state
//                SNT (strongly not taken), WNT, WTK, STK (strongly taken)
//   CTR_RESET  : state every counter returns to on reset
// The MSB of a counter is the predicted direction (1 = taken).
// ---------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WTK = 2'b10,
        STK = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = SNT;

endpackage : bp_pkg

// File: rtl/pht_sat_ctr.sv
// ---------------------------------------------------------------------------
// pht_sat_ctr
// Purely combinational next-state function of one 2-bit saturating
// direction counter.
//   state_i : current counter state
//   taken_i : resolved direction (1 = taken)
//   next_o  : counter state after training with taken_i
// Taken moves toward STK, not-taken toward SNT, both saturating.
// ---------------------------------------------------------------------------
module pht_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t state_i,
    input  logic taken_i,
    output ctr_t next_o
);

    // Walk one step along SNT-WNT-WTK-STK in the resolved direction,
    // sticking at either end.
    always_comb begin
        next_o = state_i;
        unique case (state_i)
            SNT: next_o = taken_i ? WNT : SNT;
            WNT: next_o = taken_i ? WTK : SNT;
            WTK: next_o = taken_i ? STK : WNT;
            STK: next_o = taken_i ? STK : WTK;
            default: next_o = state_i;
        endcase
    end

endmodule : pht_sat_ctr

// File: rtl/gshare_pht_predictor.sv
// ---------------------------------------------------------------------------
// gshare_pht_predictor
// Global-history (gshare) branch direction predictor for the fetch stage.
// A pattern history table of 2-bit counters is indexed by PC XOR GHR; the
// GHR is shifted speculatively with every prediction and repaired from the
// snapshot carried back with a mispredicted branch.
//
// Parameters
//   PC_W  : fetch PC width (must exceed IDX_W+2)
//   IDX_W : PHT index width, table depth 2**IDX_W
//   GHR_W : history length, 1 <= GHR_W <= IDX_W
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   i_fetch_valid   : lookup request;     i_fetch_pc : PC of the lookup
//   o_pred_valid    : registered, high one cycle after a lookup
//   o_pred_taken    : predicted direction
//   o_pred_idx      : PHT index used (returned later as i_upd_idx)
//   o_pred_ghr      : GHR used for the index, before its speculative shift
//   i_upd_valid     : resolved branch from execute
//   i_upd_idx       : index of the counter to train
//   i_upd_ghr       : history snapshot of the resolved branch
//   i_upd_taken     : resolved direction
//   i_upd_mispred   : direction was mispredicted, repair the GHR
//   o_ghr           : current speculative GHR
// Build option
//   GSHARE_PHT_BYPASS_EN : when defined, a same-cycle update to the looked-up
//                          index forwards the trained counter into the
//                          prediction; otherwise the lookup reads the old one.
// ---------------------------------------------------------------------------
module gshare_pht_predictor
    import bp_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 8,
    parameter int GHR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fetch_valid,
    input  logic [PC_W-1:0]  i_fetch_pc,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    output logic [IDX_W-1:0] o_pred_idx,
    output logic [GHR_W-1:0] o_pred_ghr,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic [GHR_W-1:0] i_upd_ghr,
    input  logic             i_upd_taken,
    input  logic             i_upd_mispred,
    output logic [GHR_W-1:0] o_ghr
);

    localparam int DEPTH = 1 << IDX_W;

    // Flat register array so every entry can take the asynchronous reset.
    ctr_t pht_q [DEPTH];

    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic             predValid_q;
    logic             predTaken_q;
    logic [IDX_W-1:0] predIdx_q;
    logic [GHR_W-1:0] predGhr_q;

    logic [IDX_W-1:0] ghrExt;
    logic [IDX_W-1:0] lookupIdx;
    ctr_t             updCur;
    ctr_t             updNext;
    ctr_t             lookupCtr;
    logic             predTaken;
    logic             recover;

    // PC bits outside the index window, and the history bit that falls off
    // the end on recovery, do not contribute to any decision.
    logic unusedBits;
    assign unusedBits = ^{i_fetch_pc[PC_W-1:IDX_W+2], i_fetch_pc[1:0], i_upd_ghr};

    // History is zero-extended on the left so short histories only perturb
    // the low index bits.
    assign ghrExt    = IDX_W'(ghr_q);
    assign lookupIdx = i_fetch_pc[IDX_W+1:2] ^ ghrExt;

    assign updCur  = pht_q[i_upd_idx];
    assign recover = i_upd_valid && i_upd_mispred;

    pht_sat_ctr uUpdCtr (
        .state_i (updCur),
        .taken_i (i_upd_taken),
        .next_o  (updNext)
    );

    // Counter that drives the prediction. The forwarding option reuses the
    // update path's next state rather than a second counter instance, since
    // on an index match it is exactly the value about to be written.
    always_comb begin
        lookupCtr = pht_q[lookupIdx];
`ifdef GSHARE_PHT_BYPASS_EN
        if (i_upd_valid && (i_upd_idx == lookupIdx)) begin
            lookupCtr = updNext;
        end
`endif
    end

    assign predTaken = lookupCtr[1];

    // Next history: a recovery rebuilds it from the branch's own snapshot
    // plus its real outcome and wins over the speculative fetch shift.
    generate
        if (GHR_W == 1) begin : gHistOne
            always_comb begin
                ghr_d = ghr_q;
                if (recover) begin
                    ghr_d = i_upd_taken;
                end else if (i_fetch_valid) begin
                    ghr_d = predTaken;
                end
            end
        end else begin : gHistMulti
            always_comb begin
                ghr_d = ghr_q;
                if (recover) begin
                    ghr_d = {i_upd_ghr[GHR_W-2:0], i_upd_taken};
                end else if (i_fetch_valid) begin
                    ghr_d = {ghr_q[GHR_W-2:0], predTaken};
                end
            end
        end
    endgenerate

    // Table training: only the resolved branch's entry moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= CTR_RESET;
            end
        end else if (i_upd_valid) begin
            pht_q[i_upd_idx] <= updNext;
        end
    end

    // History register and prediction outputs. Prediction fields hold their
    // last value between lookups; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q       <= '0;
            predValid_q <= 1'b0;
            predTaken_q <= 1'b0;
            predIdx_q   <= '0;
            predGhr_q   <= '0;
        end else begin
            ghr_q       <= ghr_d;
            predValid_q <= i_fetch_valid;
            if (i_fetch_valid) begin
                predTaken_q <= predTaken;
                predIdx_q   <= lookupIdx;
                predGhr_q   <= ghr_q;
            end
        end
    end

    assign o_pred_valid = predValid_q;
    assign o_pred_taken = predTaken_q;
    assign o_pred_idx   = predIdx_q;
    assign o_pred_ghr   = predGhr_q;
    assign o_ghr        = ghr_q;

endmodule : gshare_pht_predictor

// File: tb/tb_gshare_pht_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_pht_predictor
// Self-checking bench for gshare_pht_predictor with default parameters.
// Expected predictions are queued when a lookup is driven and compared when
// the registered outputs appear one edge later. Define GSHARE_PHT_BYPASS_EN
// for both bench and RTL to check the forwarding build.
// ---------------------------------------------------------------------------
module tb_gshare_pht_predictor;

    typedef struct packed {
        logic       taken;
        logic [7:0] idx;
        logic [7:0] ghr;
    } pred_t;

`ifdef GSHARE_PHT_BYPASS_EN
    localparam logic BYP_EXP = 1'b1;
`else
    localparam logic BYP_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_fetch_valid;
    logic [31:0] i_fetch_pc;
    logic        o_pred_valid;
    logic        o_pred_taken;
    logic [7:0]  o_pred_idx;
    logic [7:0]  o_pred_ghr;
    logic        i_upd_valid;
    logic [7:0]  i_upd_idx;
    logic [7:0]  i_upd_ghr;
    logic        i_upd_taken;
    logic        i_upd_mispred;
    logic [7:0]  o_ghr;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [1:0] modelPht [256];
    logic [7:0] modelGhr;
    pred_t      expQ [$];
    pred_t      exp;
    pred_t      lastExp;

    gshare_pht_predictor #(.PC_W(32), .IDX_W(8), .GHR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_fetch_valid (i_fetch_valid),
        .i_fetch_pc    (i_fetch_pc),
        .o_pred_valid  (o_pred_valid),
        .o_pred_taken  (o_pred_taken),
        .o_pred_idx    (o_pred_idx),
        .o_pred_ghr    (o_pred_ghr),
        .i_upd_valid   (i_upd_valid),
        .i_upd_idx     (i_upd_idx),
        .i_upd_ghr     (i_upd_ghr),
        .i_upd_taken   (i_upd_taken),
        .i_upd_mispred (i_upd_mispred),
        .o_ghr         (o_ghr)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] satNext(input logic [1:0] s, input logic t);
        if (t) return (s == 2'd3) ? 2'd3 : s + 2'd1;
        return (s == 2'd0) ? 2'd0 : s - 2'd1;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 256; i++) modelPht[i] = 2'd0;
        modelGhr = 8'h00;
        expQ.delete();
        lastExp = '0;
    endtask

    // Drive one cycle of inputs, queue the expected prediction, advance the
    // reference model, then return 1 time unit after the edge.
    task automatic applyStimulus(input logic fetch, input logic [31:0] pc,
                                 input logic uv, input logic [7:0] uidx,
                                 input logic [7:0] ughr, input logic ut,
                                 input logic um);
        logic [7:0] idx;
        logic [1:0] c;
        logic       p;
        i_fetch_valid = fetch;
        i_fetch_pc    = pc;
        i_upd_valid   = uv;
        i_upd_idx     = uidx;
        i_upd_ghr     = ughr;
        i_upd_taken   = ut;
        i_upd_mispred = um;
        idx = pc[9:2] ^ modelGhr;
        c   = modelPht[idx];
`ifdef GSHARE_PHT_BYPASS_EN
        if (uv && uidx == idx) c = satNext(modelPht[uidx], ut);
`endif
        p = c[1];
        if (fetch) expQ.push_back({p, idx, modelGhr});
        if (uv) modelPht[uidx] = satNext(modelPht[uidx], ut);
        if (uv && um) modelGhr = {ughr[6:0], ut};
        else if (fetch) modelGhr = {modelGhr[6:0], p};
        @(posedge clk);
        #1;
        i_fetch_valid = 1'b0;
        i_upd_valid   = 1'b0;
        i_upd_mispred = 1'b0;
        i_upd_taken   = 1'b0;
    endtask

    // Force GHR to zero through a recovery that trains an otherwise unused
    // entry toward not-taken.
    task automatic recoverZero();
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_fetch_valid = 0; i_fetch_pc = 0; i_upd_valid = 0; i_upd_idx = 0;
        i_upd_ghr = 0; i_upd_taken = 0; i_upd_mispred = 0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ghr} !== 18'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ghr});
        end
        testsRun++;
        if (o_ghr !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_ghr: got %h expected 00", o_ghr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_lookup();
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if ({o_pred_taken, o_pred_idx, o_pred_ghr} !== {1'b0, 8'h04, 8'h00}) begin
            testsFailed++;
            $display("[TB] FAIL first_lookup: got %h expected %h",
                     {o_pred_taken, o_pred_idx, o_pred_ghr}, {1'b0, 8'h04, 8'h00});
        end
        testsRun++;
        if (o_pred_valid !== 1'b1 || o_ghr !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL first_valid_ghr: got %b/%h expected 1/00", o_pred_valid, o_ghr);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 32'h0, 1'b1, 8'h04, 8'h00, 1'b1, 1'b0);
        testsRun++;
        if (o_pred_valid !== 1'b0 || o_pred_idx !== 8'h04) begin
            testsFailed++;
            $display("[TB] FAIL idle_hold: got valid %b idx %h expected 0/04", o_pred_valid, o_pred_idx);
        end
        recoverZero();
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if (o_pred_taken !== 1'b1 || {o_pred_taken, o_pred_idx, o_pred_ghr} !== exp) begin
            testsFailed++;
            $display("[TB] FAIL stk_predict: got %h expected %h",
                     {o_pred_taken, o_pred_idx, o_pred_ghr}, {1'b1, 8'h04, 8'h00});
        end
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 32'h0, 1'b1, 8'h04, 8'h00, 1'b1, 1'b0);
        recoverZero();
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if (o_pred_taken !== 1'b1 || o_pred_idx !== 8'h04) begin
            testsFailed++;
            $display("[TB] FAIL stk_saturate: got taken %b idx %h expected 1/04", o_pred_taken, o_pred_idx);
        end
    endtask

    task automatic test_back_to_back();
        recoverZero();
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if (o_pred_taken !== 1'b1 || o_ghr !== 8'h01) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got taken %b ghr %h expected 1/01", o_pred_taken, o_ghr);
        end
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if ({o_pred_taken, o_pred_idx, o_pred_ghr} !== {1'b0, 8'h05, 8'h01} || o_ghr !== 8'h02) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got %h ghr %h expected %h ghr 02",
                     {o_pred_taken, o_pred_idx, o_pred_ghr}, o_ghr, {1'b0, 8'h05, 8'h01});
        end
    endtask

    task automatic test_recovery();
        applyStimulus(1'b1, 32'h40, 1'b1, 8'h80, 8'h5A, 1'b1, 1'b1);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if (o_ghr !== 8'hB5) begin
            testsFailed++;
            $display("[TB] FAIL recover_ghr: got %h expected B5", o_ghr);
        end
        testsRun++;
        if ({o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ghr} !== {1'b1, 1'b0, 8'h12, 8'h02}) begin
            testsFailed++;
            $display("[TB] FAIL recover_pred: got %h expected %h",
                     {o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ghr}, {1'b1, 1'b0, 8'h12, 8'h02});
        end
        // Mispredict flag without a valid update must leave history alone.
        i_upd_mispred = 1'b1;
        i_upd_ghr     = 8'h33;
        @(posedge clk);
        #1;
        i_upd_mispred = 1'b0;
        testsRun++;
        if (o_ghr !== 8'hB5) begin
            testsFailed++;
            $display("[TB] FAIL mispred_no_valid: got %h expected B5", o_ghr);
        end
    endtask

    task automatic test_bypass();
        // idx 0x04 is STK; two not-taken updates leave it WNT.
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h04, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h04, 8'h00, 1'b0, 1'b0);
        recoverZero();
        applyStimulus(1'b1, 32'h10, 1'b1, 8'h04, 8'h00, 1'b1, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if (o_pred_taken !== BYP_EXP || o_pred_idx !== 8'h04) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_pred: got taken %b idx %h expected %b/04",
                     o_pred_taken, o_pred_idx, BYP_EXP);
        end
        testsRun++;
        if (o_ghr !== {7'h0, BYP_EXP}) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_ghr: got %h expected %h", o_ghr, {7'h0, BYP_EXP});
        end
        recoverZero();
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if (o_pred_taken !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL after_wtk: got taken %b expected 1", o_pred_taken);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 32'h44, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if ({o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ghr, o_ghr} !== 26'h0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got %h expected 0",
                     {o_pred_valid, o_pred_taken, o_pred_idx, o_pred_ghr, o_ghr});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        exp = expQ.pop_front();
        lastExp = exp;
        testsRun++;
        if ({o_pred_taken, o_pred_idx} !== {1'b0, 8'h04}) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_lookup: got %h expected %h",
                     {o_pred_taken, o_pred_idx}, {1'b0, 8'h04});
        end
    endtask

    task automatic test_random();
        logic fetch, uv, um, ut;
        logic [31:0] pc;
        logic [7:0] uidx, ughr;
        for (int n = 0; n < 200; n++) begin
            fetch = 1'($urandom_range(0, 3) != 0);
            pc    = {22'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 2'b00};
            uv    = 1'($urandom_range(0, 1));
            uidx  = 8'($urandom_range(0, 15));
            ughr  = 8'($urandom);
            ut    = 1'($urandom_range(0, 3) != 0);
            um    = 1'($urandom_range(0, 7) == 0);
            applyStimulus(fetch, pc, uv, uidx, ughr, ut, um);
            if (fetch) begin
                exp = expQ.pop_front();
                lastExp = exp;
            end
            testsRun++;
            if (o_pred_valid !== fetch || {o_pred_taken, o_pred_idx, o_pred_ghr} !== lastExp
                || o_ghr !== modelGhr) begin
                testsFailed++;
                $display("[TB] FAIL random_%0d: got v%b %h ghr %h expected v%b %h ghr %h", n,
                         o_pred_valid, {o_pred_taken, o_pred_idx, o_pred_ghr}, o_ghr,
                         fetch, lastExp, modelGhr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_lookup();
        test_saturation();
        test_back_to_back();
        test_recovery();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_gshare_pht_predictor
